// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM-sequenced control unit for the multi-cycle RV32I-subset core.
//   The FSM sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB). Memory requests use
//   ack handshakes and are bounded by a WAIT_MAX-cycle timeout. Illegal encodings and
//   timeouts park the FSM in TRAP until reset.
// Optional feature: define MUL_EXT_EN to decode R-type funct7=0000001/funct3=000 as MUL.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   opcode, funct3, funct7      IR fields, valid from the cycle after ir_we
//   imem_ack, dmem_ack          memory acks (sampled in FETCH / MEM only)
//   mul_done                    multiplier result valid (MUL_EXT_EN only)
//   imem_req, ir_we, dmem_req, ram_we, pc_we, rf_we, mul_start   strobes/requests
//   sext_op, npc_op, alu_op, alu_bsel, rf_wsel                   registered datapath controls
//   illegal, bus_err            sticky trap causes
//   state                       FETCH=0 DECODE=1 EXEC=2 MEM=3 WB=4 TRAP=5
module multicycle_ctrl #(
  parameter int unsigned WAIT_MAX = 15,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  input  logic       mul_done,
  output logic       imem_req,
  output logic       ir_we,
  output logic       dmem_req,
  output logic       ram_we,
  output logic       pc_we,
  output logic       rf_we,
  output logic [2:0] sext_op,
  output logic [2:0] npc_op,
  output logic [3:0] alu_op,
  output logic [2:0] alu_bsel,
  output logic [2:0] rf_wsel,
  output logic       mul_start,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state
);

  // Control encodings shared with the datapath
  localparam logic [2:0] EXT_NONE = 3'd0;
  localparam logic [2:0] EXT_I    = 3'd1;
  localparam logic [2:0] EXT_S    = 3'd2;
  localparam logic [2:0] EXT_B    = 3'd3;
  localparam logic [2:0] EXT_U    = 3'd4;
  localparam logic [2:0] EXT_J    = 3'd5;

  localparam logic [2:0] NPC_PC4  = 3'd0;
  localparam logic [2:0] NPC_JMP  = 3'd1;
  localparam logic [2:0] NPC_JMPR = 3'd2;
  localparam logic [2:0] NPC_COM  = 3'd3;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;

  localparam logic [2:0] ALU_RS2  = 3'd0;
  localparam logic [2:0] ALU_EXT  = 3'd1;

  localparam logic [2:0] WB_ALU   = 3'd0;
  localparam logic [2:0] WB_DRAM  = 3'd1;
  localparam logic [2:0] WB_PC4   = 3'd2;
  localparam logic [2:0] WB_EXT   = 3'd3;
  localparam logic [2:0] WB_MUL   = 3'd4;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  // Instruction class: decides the path taken after EXEC
  typedef enum logic [2:0] {
    C_WB     = 3'd0,
    C_BRANCH = 3'd1,
    C_LOAD   = 3'd2,
    C_STORE  = 3'd3,
    C_MUL    = 3'd4
  } cls_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             illegal_q, illegal_d;
  logic             bus_err_q, bus_err_d;
  cls_e             cls_q;
  logic [2:0]       sext_q, npc_q, bsel_q, wsel_q;
  logic [3:0]       alu_q;

  logic             ctl_ld;
  logic             dec_ok;
  cls_e             dec_cls;
  logic [2:0]       dec_sext, dec_npc, dec_bsel, dec_wsel;
  logic [3:0]       dec_alu;

  logic imem_req_c, ir_we_c, dmem_req_c, ram_we_c, pc_we_c, rf_we_c, mul_start_c;

  // Instruction decoder on the live IR fields; consumed only in DECODE
  always_comb begin
    dec_ok   = 1'b1;
    dec_cls  = C_WB;
    dec_sext = EXT_NONE;
    dec_npc  = NPC_PC4;
    dec_alu  = ALU_ADD;
    dec_bsel = ALU_RS2;
    dec_wsel = WB_ALU;
    case (opcode)
      OP_REG: begin
        case ({funct7, funct3})
          10'b0000000_000: dec_alu = ALU_ADD;
          10'b0100000_000: dec_alu = ALU_SUB;
          10'b0000000_100: dec_alu = ALU_XOR;
          10'b0000000_110: dec_alu = ALU_OR;
          10'b0000000_111: dec_alu = ALU_AND;
          10'b0000000_001: dec_alu = ALU_SLL;
          10'b0000000_101: dec_alu = ALU_SRL;
          10'b0100000_101: dec_alu = ALU_SRA;
`ifdef MUL_EXT_EN
          10'b0000001_000: begin
            dec_cls  = C_MUL;
            dec_wsel = WB_MUL;
          end
`endif
          default: dec_ok = 1'b0;
        endcase
      end
      OP_IMM: begin
        dec_sext = EXT_I;
        dec_bsel = ALU_EXT;
        case (funct3)
          3'b000: dec_alu = ALU_ADD;
          3'b100: dec_alu = ALU_XOR;
          3'b110: dec_alu = ALU_OR;
          3'b111: dec_alu = ALU_AND;
          3'b001: begin
            dec_alu = ALU_SLL;
            dec_ok  = (funct7 == 7'b0000000);
          end
          3'b101: begin
            dec_alu = (funct7 == 7'b0100000) ? ALU_SRA : ALU_SRL;
            dec_ok  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
          end
          default: dec_ok = 1'b0;
        endcase
      end
      OP_LUI: begin
        dec_sext = EXT_U;
        dec_wsel = WB_EXT;
      end
      OP_JAL: begin
        dec_sext = EXT_J;
        dec_npc  = NPC_JMP;
        dec_wsel = WB_PC4;
      end
      OP_JALR: begin
        dec_sext = EXT_I;
        dec_npc  = NPC_JMPR;
        dec_bsel = ALU_EXT;
        dec_wsel = WB_PC4;
        dec_ok   = (funct3 == 3'b000);
      end
      OP_LOAD: begin
        dec_cls  = C_LOAD;
        dec_sext = EXT_I;
        dec_bsel = ALU_EXT;
        dec_wsel = WB_DRAM;
        dec_ok   = (funct3 == 3'b010);
      end
      OP_STORE: begin
        dec_cls  = C_STORE;
        dec_sext = EXT_S;
        dec_bsel = ALU_EXT;
        dec_ok   = (funct3 == 3'b010);
      end
      OP_BRANCH: begin
        dec_cls  = C_BRANCH;
        dec_sext = EXT_B;
        dec_npc  = NPC_COM;
        dec_alu  = ALU_SUB;
        dec_ok   = (funct3 == 3'b000) || (funct3 == 3'b001) ||
                   (funct3 == 3'b100) || (funct3 == 3'b101);
      end
      default: dec_ok = 1'b0;
    endcase
  end

  // Next-state and strobe logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    illegal_d   = illegal_q;
    bus_err_d   = bus_err_q;
    ctl_ld      = 1'b0;
    imem_req_c  = 1'b0;
    ir_we_c     = 1'b0;
    dmem_req_c  = 1'b0;
    ram_we_c    = 1'b0;
    pc_we_c     = 1'b0;
    rf_we_c     = 1'b0;
    mul_start_c = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          ir_we_c = 1'b1;
          state_d = S_DECODE;
        end else if (cnt_q == CNT_W'(WAIT_MAX)) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        if (dec_ok) begin
          ctl_ld  = 1'b1;
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_TRAP;
        end
      end
      S_EXEC: begin
        case (cls_q)
          C_BRANCH: begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
`ifdef MUL_EXT_EN
          // cnt_q==0 marks the launch cycle; mul_done is honoured afterwards
          C_MUL: begin
            mul_start_c = (cnt_q == '0);
            if ((cnt_q != '0) && mul_done) state_d = S_WB;
            else                           cnt_d   = CNT_W'(1);
          end
`endif
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        dmem_req_c = 1'b1;
        ram_we_c   = (cls_q == C_STORE);
        if (dmem_ack) begin
          if (cls_q == C_STORE) begin
            pc_we_c = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_W'(WAIT_MAX)) begin
          state_d   = S_TRAP;
          bus_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        rf_we_c = 1'b1;
        pc_we_c = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    // Wait counter always restarts on a state change
    if (state_d != state_q) cnt_d = '0;
  end

  // FSM state, wait counter and sticky trap flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Decoded controls captured at the end of DECODE, held through EXEC/MEM/WB
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q  <= C_WB;
      sext_q <= EXT_NONE;
      npc_q  <= NPC_PC4;
      alu_q  <= ALU_ADD;
      bsel_q <= ALU_RS2;
      wsel_q <= WB_ALU;
    end else if (ctl_ld) begin
      cls_q  <= dec_cls;
      sext_q <= dec_sext;
      npc_q  <= dec_npc;
      alu_q  <= dec_alu;
      bsel_q <= dec_bsel;
      wsel_q <= dec_wsel;
    end
  end

`ifndef MUL_EXT_EN
  logic unused_mul_done;
  assign unused_mul_done = mul_done;
`endif

  // Strobes are forced low while reset is asserted
  assign imem_req  = rst_n & imem_req_c;
  assign ir_we     = rst_n & ir_we_c;
  assign dmem_req  = rst_n & dmem_req_c;
  assign ram_we    = rst_n & ram_we_c;
  assign pc_we     = rst_n & pc_we_c;
  assign rf_we     = rst_n & rf_we_c;
  assign mul_start = rst_n & mul_start_c;

  assign sext_op  = sext_q;
  assign npc_op   = npc_q;
  assign alu_op   = alu_q;
  assign alu_bsel = bsel_q;
  assign rf_wsel  = wsel_q;
  assign illegal  = illegal_q;
  assign bus_err  = bus_err_q;
  assign state    = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized bench for multicycle_ctrl. Each instruction is expanded
// into an expected per-cycle trace (stimulus + required outputs) from the instruction's
// class and its ack/multiplier latencies; the trace is then replayed against the DUT.
module tb_multicycle_ctrl;

  localparam int unsigned WAIT_MAX = 15;

  localparam bit [2:0] EXT_NONE = 3'd0, EXT_I = 3'd1, EXT_S = 3'd2, EXT_B = 3'd3,
                       EXT_U = 3'd4, EXT_J = 3'd5;
  localparam bit [2:0] NPC_PC4 = 3'd0, NPC_JMP = 3'd1, NPC_JMPR = 3'd2, NPC_COM = 3'd3;
  localparam bit [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_XOR = 4'd2, ALU_OR = 4'd3,
                       ALU_AND = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7;
  localparam bit [2:0] ALU_RS2 = 3'd0, ALU_EXT = 3'd1;
  localparam bit [2:0] WB_ALU = 3'd0, WB_DRAM = 3'd1, WB_PC4 = 3'd2, WB_EXT = 3'd3,
                       WB_MUL = 3'd4;
  localparam bit [2:0] ST_FETCH = 3'd0, ST_DECODE = 3'd1, ST_EXEC = 3'd2, ST_MEM = 3'd3,
                       ST_WB = 3'd4, ST_TRAP = 3'd5;
  localparam bit [2:0] K_WB = 3'd0, K_BR = 3'd1, K_LD = 3'd2, K_ST = 3'd3, K_MUL = 3'd4;

  logic       clk, rst_n;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic       imem_ack, dmem_ack, mul_done;
  logic       imem_req, ir_we, dmem_req, ram_we, pc_we, rf_we, mul_start, illegal, bus_err;
  logic [2:0] sext_op, npc_op, alu_bsel, rf_wsel, state;
  logic [3:0] alu_op;

  multicycle_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .imem_ack(imem_ack), .dmem_ack(dmem_ack), .mul_done(mul_done),
    .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .ram_we(ram_we),
    .pc_we(pc_we), .rf_we(rf_we), .sext_op(sext_op), .npc_op(npc_op), .alu_op(alu_op),
    .alu_bsel(alu_bsel), .rf_wsel(rf_wsel), .mul_start(mul_start), .illegal(illegal),
    .bus_err(bus_err), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       ok;
    bit [2:0] cls, sext, npc;
    bit [3:0] alu;
    bit [2:0] bsel, wsel;
  } dec_t;

  typedef struct {
    bit [6:0] op;
    bit [2:0] f3;
    bit       f3_any;
    bit [6:0] f7;
    bit       f7_any;
    dec_t     d;
  } ent_t;

  typedef struct {
    bit       rst, imem_ack, dmem_ack, mul_done;
    bit [6:0] op, f7;
    bit [2:0] f3;
    bit [2:0] st;
    bit       imem_req, ir_we, dmem_req, ram_we, pc_we, rf_we, mul_start, illegal, bus_err;
    bit       chk_ctl;
    bit [2:0] sext, npc;
    bit [3:0] alu;
    bit [2:0] bsel, wsel;
  } cyc_t;

  ent_t tbl[$];
  cyc_t q[$];
  int   vectors = 0;
  int   mis = 0;

  function automatic void add_ent(bit [6:0] op, bit [2:0] f3, bit f3a, bit [6:0] f7, bit f7a,
                                  bit [2:0] cls, bit [2:0] sx, bit [2:0] np, bit [3:0] al,
                                  bit [2:0] bs, bit [2:0] ws);
    ent_t e;
    e.op = op; e.f3 = f3; e.f3_any = f3a; e.f7 = f7; e.f7_any = f7a;
    e.d.ok = 1'b1; e.d.cls = cls; e.d.sext = sx; e.d.npc = np;
    e.d.alu = al; e.d.bsel = bs; e.d.wsel = ws;
    tbl.push_back(e);
  endfunction

  // Supported instruction list: the only encodings that may decode
  function automatic void build_table();
    add_ent(7'h33, 3'd0, 0, 7'h00, 0, K_WB, EXT_NONE, NPC_PC4, ALU_ADD, ALU_RS2, WB_ALU);
    add_ent(7'h33, 3'd0, 0, 7'h20, 0, K_WB, EXT_NONE, NPC_PC4, ALU_SUB, ALU_RS2, WB_ALU);
    add_ent(7'h33, 3'd4, 0, 7'h00, 0, K_WB, EXT_NONE, NPC_PC4, ALU_XOR, ALU_RS2, WB_ALU);
    add_ent(7'h33, 3'd6, 0, 7'h00, 0, K_WB, EXT_NONE, NPC_PC4, ALU_OR,  ALU_RS2, WB_ALU);
    add_ent(7'h33, 3'd7, 0, 7'h00, 0, K_WB, EXT_NONE, NPC_PC4, ALU_AND, ALU_RS2, WB_ALU);
    add_ent(7'h33, 3'd1, 0, 7'h00, 0, K_WB, EXT_NONE, NPC_PC4, ALU_SLL, ALU_RS2, WB_ALU);
    add_ent(7'h33, 3'd5, 0, 7'h00, 0, K_WB, EXT_NONE, NPC_PC4, ALU_SRL, ALU_RS2, WB_ALU);
    add_ent(7'h33, 3'd5, 0, 7'h20, 0, K_WB, EXT_NONE, NPC_PC4, ALU_SRA, ALU_RS2, WB_ALU);
    add_ent(7'h13, 3'd0, 0, 7'h00, 1, K_WB, EXT_I, NPC_PC4, ALU_ADD, ALU_EXT, WB_ALU);
    add_ent(7'h13, 3'd4, 0, 7'h00, 1, K_WB, EXT_I, NPC_PC4, ALU_XOR, ALU_EXT, WB_ALU);
    add_ent(7'h13, 3'd6, 0, 7'h00, 1, K_WB, EXT_I, NPC_PC4, ALU_OR,  ALU_EXT, WB_ALU);
    add_ent(7'h13, 3'd7, 0, 7'h00, 1, K_WB, EXT_I, NPC_PC4, ALU_AND, ALU_EXT, WB_ALU);
    add_ent(7'h13, 3'd1, 0, 7'h00, 0, K_WB, EXT_I, NPC_PC4, ALU_SLL, ALU_EXT, WB_ALU);
    add_ent(7'h13, 3'd5, 0, 7'h00, 0, K_WB, EXT_I, NPC_PC4, ALU_SRL, ALU_EXT, WB_ALU);
    add_ent(7'h13, 3'd5, 0, 7'h20, 0, K_WB, EXT_I, NPC_PC4, ALU_SRA, ALU_EXT, WB_ALU);
    add_ent(7'h37, 3'd0, 1, 7'h00, 1, K_WB, EXT_U, NPC_PC4, ALU_ADD, ALU_RS2, WB_EXT);
    add_ent(7'h6f, 3'd0, 1, 7'h00, 1, K_WB, EXT_J, NPC_JMP, ALU_ADD, ALU_RS2, WB_PC4);
    add_ent(7'h67, 3'd0, 0, 7'h00, 1, K_WB, EXT_I, NPC_JMPR, ALU_ADD, ALU_EXT, WB_PC4);
    add_ent(7'h03, 3'd2, 0, 7'h00, 1, K_LD, EXT_I, NPC_PC4, ALU_ADD, ALU_EXT, WB_DRAM);
    add_ent(7'h23, 3'd2, 0, 7'h00, 1, K_ST, EXT_S, NPC_PC4, ALU_ADD, ALU_EXT, WB_ALU);
    add_ent(7'h63, 3'd0, 0, 7'h00, 1, K_BR, EXT_B, NPC_COM, ALU_SUB, ALU_RS2, WB_ALU);
    add_ent(7'h63, 3'd1, 0, 7'h00, 1, K_BR, EXT_B, NPC_COM, ALU_SUB, ALU_RS2, WB_ALU);
    add_ent(7'h63, 3'd4, 0, 7'h00, 1, K_BR, EXT_B, NPC_COM, ALU_SUB, ALU_RS2, WB_ALU);
    add_ent(7'h63, 3'd5, 0, 7'h00, 1, K_BR, EXT_B, NPC_COM, ALU_SUB, ALU_RS2, WB_ALU);
`ifdef MUL_EXT_EN
    add_ent(7'h33, 3'd0, 0, 7'h01, 0, K_MUL, EXT_NONE, NPC_PC4, ALU_ADD, ALU_RS2, WB_MUL);
`endif
  endfunction

  function automatic dec_t ref_decode(bit [6:0] op, bit [2:0] f3, bit [6:0] f7);
    dec_t d;
    d.ok = 1'b0; d.cls = K_WB; d.sext = EXT_NONE; d.npc = NPC_PC4;
    d.alu = ALU_ADD; d.bsel = ALU_RS2; d.wsel = WB_ALU;
    foreach (tbl[i])
      if (tbl[i].op == op && (tbl[i].f3_any || tbl[i].f3 == f3) &&
          (tbl[i].f7_any || tbl[i].f7 == f7))
        d = tbl[i].d;
    return d;
  endfunction

  // A cycle in state st with no strobes expected and don't-care inputs randomized
  function automatic cyc_t blank(bit [2:0] st);
    cyc_t c;
    c.rst = 1'b0;
    c.imem_ack = 1'($urandom); c.dmem_ack = 1'($urandom); c.mul_done = 1'($urandom);
    c.op = 7'($urandom); c.f3 = 3'($urandom); c.f7 = 7'($urandom);
    c.st = st;
    c.imem_req = 0; c.ir_we = 0; c.dmem_req = 0; c.ram_we = 0; c.pc_we = 0; c.rf_we = 0;
    c.mul_start = 0; c.illegal = 0; c.bus_err = 0;
    c.chk_ctl = 0; c.sext = EXT_NONE; c.npc = NPC_PC4; c.alu = ALU_ADD;
    c.bsel = ALU_RS2; c.wsel = WB_ALU;
    return c;
  endfunction

  function automatic cyc_t withctl(cyc_t c, dec_t d);
    cyc_t r = c;
    r.chk_ctl = 1'b1; r.sext = d.sext; r.npc = d.npc; r.alu = d.alu;
    r.bsel = d.bsel; r.wsel = d.wsel;
    return r;
  endfunction

  function automatic cyc_t reset_rec();
    cyc_t c = blank(ST_FETCH);
    c.rst = 1'b1;
    c.chk_ctl = 1'b1;
    return c;
  endfunction

  function automatic void trap_tail(bit ill, bit be);
    cyc_t c;
    for (int i = 0; i < 20; i++) begin
      c = blank(ST_TRAP);
      c.illegal = ill; c.bus_err = be;
      q.push_back(c);
    end
    q.push_back(reset_rec());
  endfunction

  // Expected trace of one instruction. fw/mw: ack wait cycles (>WAIT_MAX = timeout);
  // mlat: multiplier latency; rst_mem: MEM cycle index where reset is applied (-1 = none)
  function automatic void add_instr(bit [6:0] op, bit [2:0] f3, bit [6:0] f7,
                                    int fw, int mw, int mlat, int rst_mem);
    dec_t d = ref_decode(op, f3, f7);
    cyc_t c;
    for (int i = 0; i < fw && i <= int'(WAIT_MAX); i++) begin
      c = blank(ST_FETCH); c.imem_ack = 0; c.imem_req = 1; q.push_back(c);
    end
    if (fw > int'(WAIT_MAX)) begin trap_tail(1'b0, 1'b1); return; end
    c = blank(ST_FETCH); c.imem_ack = 1; c.imem_req = 1; c.ir_we = 1; q.push_back(c);
    c = blank(ST_DECODE); c.op = op; c.f3 = f3; c.f7 = f7; q.push_back(c);
    if (!d.ok) begin trap_tail(1'b1, 1'b0); return; end
    if (d.cls == K_MUL) begin
      for (int k = 0; k <= mlat; k++) begin
        c = withctl(blank(ST_EXEC), d);
        c.mul_start = (k == 0); c.mul_done = (k == mlat);
        q.push_back(c);
      end
    end else begin
      c = withctl(blank(ST_EXEC), d);
      c.pc_we = (d.cls == K_BR);
      q.push_back(c);
      if (d.cls == K_BR) return;
    end
    if (d.cls == K_LD || d.cls == K_ST) begin
      for (int k = 0; k < mw && k <= int'(WAIT_MAX); k++) begin
        if (k == rst_mem) begin q.push_back(reset_rec()); return; end
        c = withctl(blank(ST_MEM), d);
        c.dmem_ack = 0; c.dmem_req = 1; c.ram_we = (d.cls == K_ST);
        q.push_back(c);
      end
      if (mw > int'(WAIT_MAX)) begin trap_tail(1'b0, 1'b1); return; end
      c = withctl(blank(ST_MEM), d);
      c.dmem_ack = 1; c.dmem_req = 1; c.ram_we = (d.cls == K_ST); c.pc_we = (d.cls == K_ST);
      q.push_back(c);
      if (d.cls == K_ST) return;
    end
    c = withctl(blank(ST_WB), d);
    c.rf_we = 1; c.pc_we = 1;
    q.push_back(c);
  endfunction

  // Pins the trace model itself against hand-computed values
  function automatic void pin(string nm, int got, int exp);
    vectors++;
    if (got != exp) begin
      mis++;
      $display("FAIL pin %s: model gives %0d, required %0d", nm, got, exp);
    end
  endfunction

  // sel: 0 dmem_req, 1 ram_we, 2 rf_we, 3 pc_we, 4 TRAP cycles, 5 FETCH cycles, 6 EXEC cycles
  function automatic int count(int from, int sel);
    int n = 0;
    for (int i = from; i < q.size(); i++)
      case (sel)
        0: n += int'(q[i].dmem_req);
        1: n += int'(q[i].ram_we);
        2: n += int'(q[i].rf_we);
        3: n += int'(q[i].pc_we);
        4: n += int'(q[i].st == ST_TRAP);
        5: n += int'(q[i].st == ST_FETCH && !q[i].rst);
        default: n += int'(q[i].st == ST_EXEC);
      endcase
    return n;
  endfunction

  function automatic int pick_wait();
    int r = int'($urandom_range(0, 19));
    if (r == 0) return 16;
    if (r == 1) return 15;
    return int'($urandom_range(0, 3));
  endfunction

  task automatic play();
    cyc_t c;
    logic [6:0]  gs, es;
    logic [15:0] gc, ec;
    bit ok;
    for (int i = 0; i < q.size(); i++) begin
      c = q[i];
      @(posedge clk);
      #1;
      rst_n = !c.rst;
      imem_ack = c.imem_ack; dmem_ack = c.dmem_ack; mul_done = c.mul_done;
      opcode = c.op; funct3 = c.f3; funct7 = c.f7;
      @(negedge clk);
      gs = {imem_req, ir_we, dmem_req, ram_we, pc_we, rf_we, mul_start};
      es = {c.imem_req, c.ir_we, c.dmem_req, c.ram_we, c.pc_we, c.rf_we, c.mul_start};
      gc = {sext_op, npc_op, alu_op, alu_bsel, rf_wsel};
      ec = {c.sext, c.npc, c.alu, c.bsel, c.wsel};
      ok = (state == c.st) && (gs == es) && (illegal == c.illegal) &&
           (bus_err == c.bus_err) && (!c.chk_ctl || gc == ec);
      vectors++;
      if (!ok) begin
        mis++;
        $display("FAIL cyc%0d: got state=%0d strb=%b ill=%b berr=%b ctl=%h; required state=%0d strb=%b ill=%b berr=%b ctl=%h (ctl checked=%0d)",
                 i, state, gs, illegal, bus_err, gc, c.st, es, c.illegal, c.bus_err, ec, c.chk_ctl);
      end
    end
  endtask

  initial begin
    int n0;
    ent_t e;
    rst_n = 1'b0; imem_ack = 0; dmem_ack = 0; mul_done = 0;
    opcode = '0; funct3 = '0; funct7 = '0;
    build_table();
    q.push_back(reset_rec());

    n0 = q.size(); add_instr(7'b0110011, 3'b000, 7'b0000000, 0, 0, 0, -1);
    pin("add_len", q.size() - n0, 4);
    pin("add_states", int'({q[n0].st, q[n0+1].st, q[n0+2].st, q[n0+3].st}),
        int'({3'd0, 3'd1, 3'd2, 3'd4}));
    pin("add_wb", int'({q[n0+3].rf_we, q[n0+3].pc_we, q[n0+3].alu}), int'({2'b11, ALU_ADD}));

    n0 = q.size(); add_instr(7'b0000011, 3'b010, 7'h15, 0, 3, 0, -1);
    pin("lw_dreq", count(n0, 0), 4);
    pin("lw_ramwe", count(n0, 1), 0);
    pin("lw_wsel", int'(q[q.size()-1].wsel), int'(WB_DRAM));

    n0 = q.size(); add_instr(7'b0100011, 3'b010, 7'h40, 0, 0, 0, -1);
    pin("sw_len", q.size() - n0, 4);
    pin("sw_ramwe", count(n0, 1), 1);
    pin("sw_rfwe", count(n0, 2), 0);
    pin("sw_pcwe_last", int'(q[n0+3].pc_we), 1);

    n0 = q.size(); add_instr(7'b1100011, 3'b000, 7'h00, 0, 0, 0, -1);
    pin("beq_len", q.size() - n0, 3);
    pin("beq_npc", int'(q[n0+2].npc), int'(NPC_COM));
    pin("beq_rfwe", count(n0, 2), 0);

    n0 = q.size(); add_instr(7'b0000000, 3'b000, 7'h00, 1, 0, 0, -1);
    pin("ill_trap", count(n0, 4), 20);

    n0 = q.size(); add_instr(7'b0000011, 3'b010, 7'h00, 0, 5, 0, 2);
    pin("rst_mid_mem_len", q.size() - n0, 6);

    n0 = q.size(); add_instr(7'b0110011, 3'b100, 7'h00, 16, 0, 0, -1);
    pin("fetch_to_fetch", count(n0, 5), 16);
    pin("fetch_to_berr", int'(q[n0+16].bus_err), 1);

    add_instr(7'b0100011, 3'b010, 7'h00, 0, 16, 0, -1);
    add_instr(7'b0110011, 3'b000, 7'h01, 0, 0, 5, -1);
`ifdef MUL_EXT_EN
    n0 = q.size(); add_instr(7'b0110011, 3'b000, 7'h01, 0, 0, 5, -1);
    pin("mul_exec", count(n0, 6), 6);
    pin("mul_wsel", int'(q[q.size()-1].wsel), int'(WB_MUL));
`endif

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 99) < 85) begin
        e = tbl[$urandom_range(0, tbl.size() - 1)];
        add_instr(e.op, e.f3_any ? 3'($urandom) : e.f3, e.f7_any ? 7'($urandom) : e.f7,
                  pick_wait(), pick_wait(), int'($urandom_range(1, 6)), -1);
      end else begin
        add_instr(7'($urandom), 3'($urandom), 7'($urandom), pick_wait(), pick_wait(),
                  int'($urandom_range(1, 6)), -1);
      end
    end

    play();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, mis);
    $finish;
  end

endmodule
